// File: rtl/fib_req_scheduler.sv
// Round-robin request scheduler feeding an iterative Fibonacci engine (one add per cycle).
// Build option FIB_OVF_SAT_EN: saturate result to all ones when any addition overflowed.
module fib_req_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] n_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      result,
  output logic                  ovf
);

`ifdef FIB_OVF_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [IDW-1:0]   last_id;
  logic [IDW-1:0]   id_lat;
  logic [IDW-1:0]   pick_id;
  logic             pick_vld;
  logic [WIDTH-1:0] n_sel;
  logic [WIDTH-1:0] n_lat;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             ovf_int;

  function automatic logic [WIDTH-1:0] fmt_result(input logic [WIDTH-1:0] n_val,
                                                  input logic [WIDTH-1:0] b_val,
                                                  input logic             ov_val);
    if (n_val == '0) return '0;
    if (ov_val && SAT_EN) return '1;
    return b_val;
  endfunction

  // Search starts just after the last grant; descending loop lets the nearest index win.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IDW'((int'(last_id) + k) % NREQ)]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'((int'(last_id) + k) % NREQ);
      end
    end
  end

  always_comb begin
    n_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) n_sel = n_in[i*WIDTH +: WIDTH];
    end
  end

  assign sum = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_id <= IDW'(NREQ - 1);
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      ovf_int <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state   <= CALC;
            gnt     <= NREQ'(1) << pick_id;
            busy    <= 1'b1;
            last_id <= pick_id;
            id_lat  <= pick_id;
            n_lat   <= n_sel;
            cnt     <= n_sel;
            a       <= '0;
            b       <= WIDTH'(1);
            ovf_int <= 1'b0;
          end
        end
        CALC: begin
          gnt <= '0;
          if (cnt < WIDTH'(2)) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= id_lat;
            result  <= fmt_result(n_lat, b, ovf_int);
            ovf     <= ovf_int;
          end else begin
            a   <= b;
            b   <= sum[WIDTH-1:0];
            cnt <= cnt - WIDTH'(1);
            if (sum[WIDTH]) ovf_int <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_req_scheduler.sv
// Self-checking bench for fib_req_scheduler: directed scenarios plus randomized traffic
// against an arithmetic Fibonacci / round-robin reference model.
module tb_fib_req_scheduler;
  localparam int W    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef FIB_OVF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] n_in;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [W-1:0]      result;
  logic              ovf;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_gnt = NREQ - 1;
  int n_of [NREQ];

  fib_req_scheduler #(.WIDTH(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .n_in(n_in), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // True Fibonacci value; overflow means F(n) does not fit in W bits.
  task automatic fib_model(input int n, output logic [W-1:0] r, output logic o);
    longint unsigned f0, f1, t;
    f0 = 0;
    f1 = 1;
    for (int k = 0; k < n; k++) begin
      t = f0 + f1;
      f0 = f1;
      f1 = t;
    end
    o = (f0 >= (64'd1 << W));
    r = f0[W-1:0];
    if (o && SAT) r = '1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int id, input int n);
    req[id] = 1'b1;
    n_of[id] = n;
    n_in[id*W +: W] = W'(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    last_gnt = NREQ - 1;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin
      tick();
      waited++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL drain: busy=%b expected 0", busy);
    else passes++;
  endtask

  // Called with the DUT idle and req nonzero: expects the grant on the next edge,
  // then the done pulse max(n,1) cycles later with the modelled result.
  task automatic run_txn();
    int id, exp_lat, lat;
    logic [W-1:0] er;
    logic eo;
    logic [NREQ-1:0] eg;
    bit seen, extra_gnt;
    id = rr_pick(req, last_gnt);
    fib_model(n_of[id], er, eo);
    exp_lat = (n_of[id] < 1) ? 1 : n_of[id];
    eg = '0;
    eg[id] = 1'b1;
    tick();
    checks++;
    if (gnt !== eg) $display("FAIL txn_gnt: gnt=%b expected %b", gnt, eg);
    else passes++;
    last_gnt = id;
    req[id] = 1'b0;
    n_in[id*W +: W] = W'($urandom);
    lat = 0;
    seen = 0;
    extra_gnt = 0;
    while (!seen && lat < exp_lat + 4) begin
      tick();
      lat++;
      if (gnt !== '0) extra_gnt = 1;
      seen = (done === 1'b1);
    end
    checks++;
    if (!seen || lat != exp_lat)
      $display("FAIL txn_latency: n=%0d latency=%0d seen=%0d expected %0d", n_of[id], lat, seen, exp_lat);
    else passes++;
    checks++;
    if (extra_gnt) $display("FAIL txn_gnt_width: gnt stayed high after first CALC cycle, expected one-cycle pulse");
    else passes++;
    checks++;
    if (result !== er) $display("FAIL txn_result: n=%0d result=%0d expected %0d", n_of[id], result, er);
    else passes++;
    checks++;
    if (done_id !== IDW'(id)) $display("FAIL txn_done_id: done_id=%0d expected %0d", done_id, id);
    else passes++;
    checks++;
    if (ovf !== eo) $display("FAIL txn_ovf: n=%0d ovf=%b expected %b", n_of[id], ovf, eo);
    else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL txn_busy_done: busy=%b expected 1", busy);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL txn_idle: done=%b busy=%b expected 0 0", done, busy);
    else passes++;
    checks++;
    if (result !== er) $display("FAIL txn_hold: result=%0d expected %0d", result, er);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    n_in = '0;
    tick();
    tick();
    checks++;
    if (gnt !== '0) $display("FAIL reset_gnt: gnt=%b expected 0", gnt); else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b expected 0", busy); else passes++;
    checks++;
    if (done !== 1'b0) $display("FAIL reset_done: done=%b expected 0", done); else passes++;
    checks++;
    if (done_id !== '0) $display("FAIL reset_done_id: done_id=%0d expected 0", done_id); else passes++;
    checks++;
    if (result !== '0) $display("FAIL reset_result: result=%0d expected 0", result); else passes++;
    checks++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: ovf=%b expected 0", ovf); else passes++;
    rst = 1'b0;
    last_gnt = NREQ - 1;
  endtask

  task automatic test_directed();
    set_req(0, 10); run_txn();
    set_req(1, 13); run_txn();
    set_req(2, 14); run_txn();
    set_req(3, 0);  run_txn();
    set_req(0, 1);  run_txn();
  endtask

  task automatic test_round_robin();
    int exp_id, prev_cyc, waited;
    logic [NREQ-1:0] eg;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1);
    prev_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (gnt === '0 && waited < 8);
      exp_id = rr_pick(req, last_gnt);
      eg = '0;
      eg[exp_id] = 1'b1;
      checks++;
      if (gnt !== eg) $display("FAIL rr_order: grant %0d gnt=%b expected %b", g, gnt, eg);
      else passes++;
      if (g > 0) begin
        checks++;
        if (cyc - prev_cyc != 3)
          $display("FAIL rr_spacing: grant %0d spacing=%0d expected 3", g, cyc - prev_cyc);
        else passes++;
      end
      prev_cyc = cyc;
      last_gnt = exp_id;
    end
    req = '0;
    drain();
  endtask

  task automatic test_reset_mid_calc();
    int waited;
    bit saw_done;
    do_reset();
    set_req(2, 20);
    tick();
    checks++;
    if (gnt !== 4'b0100) $display("FAIL midrst_gnt2: gnt=%b expected 0100", gnt); else passes++;
    set_req(0, 3);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || gnt !== '0)
      $display("FAIL midrst_clear: busy=%b done=%b gnt=%b expected 0 0 0000", busy, done, gnt);
    else passes++;
    rst = 1'b0;
    last_gnt = NREQ - 1;
    saw_done = 0;
    waited = 0;
    do begin
      tick();
      waited++;
      if (done === 1'b1) saw_done = 1;
    end while (gnt === '0 && waited < 8);
    checks++;
    if (gnt !== 4'b0001) $display("FAIL midrst_next: gnt=%b expected 0001", gnt); else passes++;
    checks++;
    if (saw_done) $display("FAIL midrst_nodone: done=1 observed, expected abandoned computation");
    else passes++;
    last_gnt = 0;
    req = '0;
    drain();
  endtask

  task automatic test_pulse_ignore();
    bit saw_g3, saw_done;
    logic [W-1:0] er;
    logic eo;
    set_req(1, 10);
    fib_model(10, er, eo);
    tick();
    checks++;
    if (gnt !== 4'b0010) $display("FAIL pulse_gnt1: gnt=%b expected 0010", gnt); else passes++;
    last_gnt = 1;
    req = '0;
    tick();
    tick();
    set_req(3, 5);
    tick();
    req = '0;
    saw_g3 = 0;
    saw_done = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (gnt[3] === 1'b1) saw_g3 = 1;
      if (done === 1'b1 && done_id === 2'd1 && result === er) saw_done = 1;
    end
    checks++;
    if (saw_g3) $display("FAIL pulse_ignore: gnt[3]=1 observed, expected never");
    else passes++;
    checks++;
    if (!saw_done) $display("FAIL pulse_done1: done for id 1 result %0d not observed", er);
    else passes++;
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          n = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 16);
          set_req(i, n);
        end
      end
      if (req == '0) set_req($urandom_range(0, NREQ - 1), $urandom_range(0, 16));
      run_txn();
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    n_in = '0;
    for (int i = 0; i < NREQ; i++) n_of[i] = 0;
    test_reset();
    test_directed();
    test_round_robin();
    test_reset_mid_calc();
    test_pulse_ignore();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fib_req_scheduler.md
FIB_REQ_SCHEDULER -- requirements
Module: fib_req_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand and result width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, which sets the number of requesters (minimum 2).
REQ-003 The block SHALL have localparam IDW = $clog2(NREQ), the width of a requester index.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester request level.
REQ-007 The block SHALL have port n_in, input, NREQ*WIDTH bits: requester i's index n in bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port gnt, output, NREQ bits: one-hot, one-cycle acceptance pulse.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a computation is in flight (CALC or DONE).
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port done_id, output, IDW bits: index of the requester whose result is presented.
REQ-012 The block SHALL have port result, output, WIDTH bits: F(n) for the completed request.
REQ-013 The block SHALL have port ovf, output, 1 bit: at least one addition of the completed request exceeded WIDTH bits.

Function
REQ-014 The block SHALL implement FSM states IDLE, CALC and DONE, with transitions IDLE->CALC on acceptance, CALC->DONE when cnt<=1, and DONE->IDLE unconditionally.
REQ-015 In IDLE with any req bit high at an edge, the block SHALL accept exactly one requester, chosen round-robin starting from the index after the last granted and wrapping.
REQ-016 At acceptance the block SHALL latch n, the id and cnt=n, and set a=0, b=1, ovf_int=0.
REQ-017 The block SHALL pulse gnt[id] high in the first CALC cycle only, and all gnt bits SHALL be 0 otherwise.
REQ-018 In CALC with cnt>1, the block SHALL perform one iteration per cycle: a<=b, b<=(a+b) mod 2^WIDTH, cnt<=cnt-1, and set ovf_int on carry-out; ovf_int SHALL be sticky for the operation.
REQ-019 In CALC with cnt<=1, the block SHALL go to DONE without iterating.
REQ-020 In DONE, done SHALL be 1, done_id SHALL equal the latched id, and result SHALL be 0 if n==0, else b (subject to REQ-027).
REQ-021 The done pulse SHALL rise exactly max(n,1) cycles after the gnt pulse.
REQ-022 result, done_id and ovf SHALL hold their values until the next done.
REQ-023 The block SHALL not re-arbitrate before the IDLE cycle following DONE, giving a minimum request-to-request spacing of max(n,1)+2 cycles.
REQ-024 Requesters SHALL hold req and n_in until gnt; a req deasserted before acceptance SHALL not be served, and n_in changes after acceptance SHALL be ignored.
REQ-025 Request lines that are not granted SHALL stay pending without loss; a requester re-requesting immediately SHALL be placed after all other pending requesters.

Reset
REQ-026 On rst at an edge, the block SHALL go to IDLE and clear gnt, busy, done, done_id, result and ovf to 0. It SHALL reset the round-robin pointer so requester 0 has the highest priority. Any in-flight computation SHALL be abandoned with no done. rst SHALL take priority over every other event.

Configuration
REQ-027 With macro FIB_OVF_SAT_EN defined, a completed request with ovf=1 SHALL present result = all ones (2^WIDTH-1). Without the macro, result SHALL be the wrapped value (mod 2^WIDTH). ovf SHALL be reported identically in both builds.

Verification
REQ-028 Directed scenario (WIDTH=8): req=4'b0001, n=10 -> gnt[0] for one cycle; 10 cycles later done=1, result=55, done_id=0, ovf=0.
REQ-029 Directed scenario: n=13 -> result=233, ovf=0. n=14 -> ovf=1 and result=121; with FIB_OVF_SAT_EN defined, result=255.
REQ-030 Directed scenario: n=0 -> result=0, and done follows 1 cycle after gnt. n=1 -> result=1, and done follows 1 cycle after gnt.
REQ-031 Directed scenario: req=4'b1111 held, all n=1 -> grants in order 0,1,2,3,0, with 3 cycles between consecutive gnt pulses.
REQ-032 Directed scenario: rst asserted mid-CALC of requester 2 with req=4'b0101 pending -> no done; the next grant goes to requester 0.
REQ-033 Directed scenario: req[3] pulsed for one cycle while busy -> gnt[3] is never asserted.
